// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle between the sequencer (master) and the control decoder / top level (slave).
interface fetch_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CYC_W = 16
);
  logic              Start;
  logic [PC_W-1:0]   ProgCtr;
  logic [8:0]        InstrIn;
  logic [8:0]        Instruction;
  logic [8:0]        PrevInstruction;
  logic [1:0]        CurrState;
  logic [2:0]        CMPBits;
  logic              BranchEn;
  logic [8:0]        BranchTarget;
  logic [1:0]        NextState;
  logic [8:0]        PrevInstructionIn;
  logic [2:0]        CMPBitsIn;
  logic              CMPLoadEn;
  logic              Ack;
  logic              Running;
  logic              Done;
  logic              Fault;
  logic [CYC_W-1:0]  CycleCount;

  modport master (
    input  Start, InstrIn, BranchEn, BranchTarget, NextState,
           PrevInstructionIn, CMPBitsIn, CMPLoadEn, Ack,
    output ProgCtr, Instruction, PrevInstruction, CurrState, CMPBits,
           Running, Done, Fault, CycleCount
  );

  modport slave (
    output Start, InstrIn, BranchEn, BranchTarget, NextState,
           PrevInstructionIn, CMPBitsIn, CMPLoadEn, Ack,
    input  ProgCtr, Instruction, PrevInstruction, CurrState, CMPBits,
           Running, Done, Fault, CycleCount
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC / fetch sequencer: owns PC, decoder mode, PrevInstruction and CMP flags; Start/Done handshake.
// Decoder decisions land one cycle later; Instruction is a NOP whenever the program is not running.
module fetch_sequencer #(
  parameter int PC_W       = 10,
  parameter int PROG_DEPTH = 1024,
  parameter int START_ADDR = 0,
  parameter int CYC_W      = 16
) (
  input logic Clk,
  input logic Reset,
  fetch_sequencer_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALT = 2'd2} state_t;

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);
  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(PROG_DEPTH - 1);

  state_t           state;
  logic [PC_W-1:0]  pc;
  logic [1:0]       curr_state;
  logic [8:0]       prev_instr;
  logic [2:0]       cmp_bits;
  logic             running;
  logic             done;
  logic             fault;
  logic [CYC_W-1:0] cyc_cnt;
  logic             target_oob;
  logic [1:0]       next_mode;

  assign target_oob = {23'd0, bus.BranchTarget} >= 32'(PROG_DEPTH);
  // Mode 11 is not a legal decoder mode; fall back to register mode.
  assign next_mode  = (bus.NextState == 2'b11) ? 2'b00 : bus.NextState;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      pc         <= START_PC;
      curr_state <= 2'b00;
      prev_instr <= 9'h000;
      cmp_bits   <= 3'b000;
      running    <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
      cyc_cnt    <= '0;
    end else begin
      case (state)
        IDLE, HALT: begin
          if (bus.Start) begin
            state      <= RUN;
            running    <= 1'b1;
            pc         <= START_PC;
            curr_state <= 2'b00;
            prev_instr <= 9'h000;
            cmp_bits   <= 3'b000;
            cyc_cnt    <= '0;
            done       <= 1'b0;
            fault      <= 1'b0;
          end
        end
        RUN: begin
          if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 1'b1;
          if (bus.Ack) begin
            state   <= HALT;
            running <= 1'b0;
            done    <= 1'b1;
          end else begin
            curr_state <= next_mode;
            prev_instr <= bus.PrevInstructionIn;
            if (bus.CMPLoadEn) cmp_bits <= bus.CMPBitsIn;
            if (bus.BranchEn) begin
              pc <= PC_W'(bus.BranchTarget);
              if (target_oob) begin
                state   <= HALT;
                running <= 1'b0;
                fault   <= 1'b1;
              end
            end else if (pc == LAST_PC) begin
              // Falling off the end of the program halts rather than wrapping.
              state   <= HALT;
              running <= 1'b0;
              fault   <= 1'b1;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ProgCtr         = pc;
  assign bus.Instruction     = (state == RUN) ? bus.InstrIn : 9'h000;
  assign bus.PrevInstruction = prev_instr;
  assign bus.CurrState       = curr_state;
  assign bus.CMPBits         = cmp_bits;
  assign bus.Running         = running;
  assign bus.Done            = done;
  assign bus.Fault           = fault;
  assign bus.CycleCount      = cyc_cnt;
endmodule
